staticram_master: RTL and testbench



---
 rtl/staticram_master.sv | 165 ++++++++++++++++
 tb/tb_staticram_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/staticram_master.sv
// Valid/ready bus master driving the two-phase static RAM strobe sequence.
// Define STATICRAM_MASTER_IDLE_X_EN to drive mem_addr/mem_din to all-x while idle or in reset.
module staticram_master #(
    parameter int WordSize  = 16,
    parameter int AddrWidth = 16
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [WordSize-1:0]  req_wdata,
    output logic                 rsp_valid,
    output logic [WordSize-1:0]  rsp_rdata,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [WordSize-1:0]  mem_din,
    input  logic [WordSize-1:0]  mem_dout,
    output logic                 mem_clk2,
    output logic                 mem_clk1,
    output logic                 mem_rd,
    output logic                 mem_wr
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SETA = 3'd1,
        STB2 = 3'd2,
        CTRL = 3'd3,
        STB1 = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WordSize-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
    logic [WordSize-1:0]    mem_din_q, mem_din_d;
    logic                   mem_clk2_q, mem_clk2_d;
    logic                   mem_clk1_q, mem_clk1_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;

    // Every output is computed for the state being entered, so each one is a plain flop.
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d     = state_q;
        we_d        = we_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_clk2_d  = mem_clk2_q;
        mem_clk1_d  = mem_clk1_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = SETA;
                    we_d        = req_we;
                    mem_addr_d  = req_addr;
                    mem_din_d   = req_wdata;
                    req_ready_d = 1'b0;
                end
            end
            SETA: begin
                state_d    = STB2;
                mem_clk2_d = 1'b1;
            end
            STB2: begin
                state_d    = CTRL;
                mem_clk2_d = 1'b0;
                mem_rd_d   = ~we_q;
                mem_wr_d   = we_q;
            end
            CTRL: begin
                state_d    = STB1;
                mem_clk1_d = 1'b1;
            end
            STB1: begin
                state_d     = DONE;
                mem_clk1_d  = 1'b0;
                mem_rd_d    = 1'b0;
                mem_wr_d    = 1'b0;
                rsp_valid_d = 1'b1;
                // Read data is captured on the edge that closes the data strobe.
                if (!we_q) begin
                    rsp_rdata_d = mem_dout;
                end
            end
            DONE: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
`ifdef STATICRAM_MASTER_IDLE_X_EN
                mem_addr_d  = 'x;
                mem_din_d   = 'x;
`endif
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                mem_clk2_d  = 1'b0;
                mem_clk1_d  = 1'b0;
                mem_rd_d    = 1'b0;
                mem_wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef STATICRAM_MASTER_IDLE_X_EN
            mem_addr_q  <= 'x;
            mem_din_q   <= 'x;
`else
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
`endif
            mem_clk2_q  <= 1'b0;
            mem_clk1_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            state_q     <= state_d;
            we_q        <= we_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_clk2_q  <= mem_clk2_d;
            mem_clk1_q  <= mem_clk1_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_clk2  = mem_clk2_q;
    assign mem_clk1  = mem_clk1_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;

    a_cmd_excl: assert property (@(posedge sclk) disable iff (!rst_n) !(mem_rd && mem_wr));
    a_stb_excl: assert property (@(posedge sclk) disable iff (!rst_n) !(mem_clk1 && mem_clk2));
    a_clk1_cmd: assert property (@(posedge sclk) disable iff (!rst_n) mem_clk1 |-> (mem_rd || mem_wr));

endmodule

// File: tb/tb_staticram_master.sv
// Directed bench for staticram_master: vector table of accesses plus back-to-back and reset-abort sequences.
module tb_staticram_master;

    logic        sclk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_clk2;
    logic        mem_clk1;
    logic        mem_rd;
    logic        mem_wr;

    int checks;
    int failures;
    int cyc;

    staticram_master #(.WordSize(16), .AddrWidth(16)) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_clk2  (mem_clk2),
        .mem_clk1  (mem_clk1),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    // Static RAM model: address latched on the mem_clk2 rise, write on the mem_clk1 rise.
    logic [15:0] ram [256];
    logic [7:0]  lat_addr;
    always @(posedge mem_clk2) lat_addr <= mem_addr[7:0];
    always @(posedge mem_clk1) if (mem_wr) ram[lat_addr] <= mem_din;
    assign mem_dout = ram[lat_addr];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issues one access from a negedge and checks every cycle through the return to IDLE.
    task automatic run_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] exp_rdata, input string tag);
        logic [5:0] exp_ctl;
        logic [5:0] act_ctl;
        int waited;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge sclk);
            waited++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge sclk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        for (int k = 1; k <= 6; k++) begin
            @(negedge sclk);
            // {req_ready, rsp_valid, mem_clk2, mem_clk1, mem_rd, mem_wr}
            case (k)
                1:       exp_ctl = 6'b000000;
                2:       exp_ctl = 6'b001000;
                3:       exp_ctl = {4'b0000, ~we, we};
                4:       exp_ctl = {4'b0001, ~we, we};
                5:       exp_ctl = 6'b010000;
                default: exp_ctl = 6'b100000;
            endcase
            act_ctl = {req_ready, rsp_valid, mem_clk2, mem_clk1, mem_rd, mem_wr};
            check($sformatf("%s ctl k=%0d", tag, k), 32'(act_ctl), 32'(exp_ctl));
            if (k <= 5) begin
                check($sformatf("%s addr k=%0d", tag, k), 32'(mem_addr), 32'(addr));
                check($sformatf("%s din k=%0d", tag, k), 32'(mem_din), 32'(wdata));
            end else begin
`ifdef STATICRAM_MASTER_IDLE_X_EN
                check({tag, " idle addr x"}, 32'($isunknown(mem_addr)), 32'd1);
`else
                check({tag, " idle addr hold"}, 32'(mem_addr), 32'(addr));
`endif
            end
            if (k >= 5) begin
                check($sformatf("%s rdata k=%0d", tag, k), 32'(rsp_rdata), 32'(exp_rdata));
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, acc1, waited;
        logic [15:0] r0;
        logic        seen0, seen_rsp;

        vecs[0] = '{1'b1, 16'h0002, 16'h06CF, 16'h0000};
        vecs[1] = '{1'b0, 16'h0002, 16'h0000, 16'h06CF};
        vecs[2] = '{1'b1, 16'h000A, 16'h1234, 16'h06CF};
        vecs[3] = '{1'b1, 16'h0001, 16'hABCD, 16'h06CF};
        vecs[4] = '{1'b1, 16'h0005, 16'h1111, 16'h06CF};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h06CF};
        vecs[6] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A};
        vecs[7] = '{1'b0, 16'h000A, 16'h0000, 16'h1234};

        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge sclk);
        rst_n = 1'b1;
        repeat (10) @(negedge sclk);

        check("reset ctl", 32'({req_ready, rsp_valid, mem_clk2, mem_clk1, mem_rd, mem_wr}), 32'b100000);
        check("reset rdata", 32'(rsp_rdata), 32'd0);
`ifdef STATICRAM_MASTER_IDLE_X_EN
        check("reset addr x", 32'($isunknown(mem_addr)), 32'd1);
        check("reset din x", 32'($isunknown(mem_din)), 32'd1);
`else
        check("reset addr", 32'(mem_addr), 32'd0);
        check("reset din", 32'(mem_din), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                       $sformatf("vec%0d", i));
            if (i == 0) check("ram[2] after write", 32'(ram[8'h02]), 32'h06CF);
        end

        // Back-to-back reads with req_valid held high.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h000A; req_wdata = 16'h7777;
        @(posedge sclk);
        acc0 = cyc;
        #1;
        req_addr = 16'h0001;
        seen0 = 1'b0; r0 = '0; waited = 0;
        do begin
            @(negedge sclk);
            waited++;
            if (rsp_valid) begin seen0 = 1'b1; r0 = rsp_rdata; end
        end while (!req_ready && waited < 20);
        @(posedge sclk);
        acc1 = cyc;
        #1;
        req_addr = 16'h00FF; req_we = 1'b1; req_valid = 1'b0;
        check("b2b first rsp seen", 32'(seen0), 32'd1);
        check("b2b first rdata", 32'(r0), 32'h1234);
        check("b2b accept gap", 32'(acc1 - acc0), 32'd6);
        seen_rsp = 1'b0; waited = 0;
        while (!seen_rsp && waited < 20) begin
            @(negedge sclk);
            waited++;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check("b2b second rsp seen", 32'(seen_rsp), 32'd1);
        check("b2b second latency", 32'(waited), 32'd5);
        check("b2b second rdata", 32'(rsp_rdata), 32'hABCD);
        check("b2b mem_wr idle", 32'(mem_wr), 32'd0);
        @(negedge sclk);

        // Reset during STB2 of a write to 0x0005.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'hBEEF;
        @(posedge sclk);
        #1;
        req_valid = 1'b0;
        @(negedge sclk);
        @(negedge sclk);
        check("abort in STB2", 32'(mem_clk2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort ctl", 32'({req_ready, rsp_valid, mem_clk2, mem_clk1, mem_rd, mem_wr}), 32'b100000);
`ifndef STATICRAM_MASTER_IDLE_X_EN
        check("abort addr", 32'(mem_addr), 32'd0);
        check("abort din", 32'(mem_din), 32'd0);
`endif
        seen_rsp = 1'b0;
        repeat (3) begin
            @(negedge sclk);
            if (rsp_valid || mem_clk1) seen_rsp = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge sclk);
            if (rsp_valid || mem_clk1) seen_rsp = 1'b1;
        end
        check("abort no rsp", 32'(seen_rsp), 32'd0);
        check("abort rdata reset", 32'(rsp_rdata), 32'd0);
        check("abort ram untouched", 32'(ram[8'h05]), 32'h1111);

        run_access(1'b0, 16'h0005, 16'h0000, 16'h1111, "post-reset read");
        run_access(1'b0, 16'h0002, 16'h0000, 16'h06CF, "final read");
        repeat (3) @(negedge sclk);
`ifdef STATICRAM_MASTER_IDLE_X_EN
        check("final idle addr x", 32'($isunknown(mem_addr)), 32'd1);
`else
        check("final idle addr", 32'(mem_addr), 32'h0002);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
